vec_exec_stage: RTL and testbench
=================================

// Module: vec_exec_stage
// PURPOSE
//  Parametrised SIMD execute stage for the filter GPU pipeline: LANES x WIDTH operands.
//  Contains the ID/EX register, M/W forwarding, per-lane ALU, neighbour-address generation and the EX/MEM register.
//  Also contains NZCV flag storage and load-use hazard detection.
//  Sits between decode (register file read) and data memory; writeback feeds result_w back in.
// PARAMETERS
//  LANES   3   vector lanes per instruction
//  WIDTH   18  bits per lane
//  ADDR_W  10  memory address width, taken from lane 0 result
//  STRIDE  1   neighbour offset for addr_p_m / addr_n_m
//  SAT_EN  0   1: ADD/SUB saturate per lane (signed); 0: wrap
// PORTS
//  CLK          in   1              clock, rising edge
//  RST          in   1              asynchronous reset, active-high
//  valid_d      in   1              decode-stage instruction valid
//  rd1_d,rd2_d  in   LANES*WIDTH    register operands
//  imm_d        in   WIDTH          extended immediate, broadcast to all lanes
//  ra1_d,ra2_d  in   4              source register numbers
//  wa3_d        in   4              destination register
//  alu_ctrl_d   in   4              gpu_pkg::alu_op_t
//  alu_src_d    in   1              1: B = imm_d
//  reg_write_d, mem_to_reg_d, mem_write_d  in 1 each   control bits
//  flag_write_d in   1              update NZCV at E
//  stall_e      in   1              hold ID/EX contents
//  flush_e      in   1              replace ID/EX with bubble
//  wa3_w        in   4              writeback destination
//  reg_write_w  in   1              writeback write enable
//  result_w     in   LANES*WIDTH    writeback data
//  ldu_stall    out  1              load-use hazard; decode must stall
//  valid_m      out  1              EX/MEM valid
//  alu_result_m out  LANES*WIDTH    ALU result
//  write_data_m out  LANES*WIDTH    forwarded B operand (pre-immediate mux), used for stores
//  addr_p_m, addr_n_m  out ADDR_W   lane-0 address +STRIDE / -STRIDE
//  wa3_m        out  4              destination register
//  reg_write_m, mem_to_reg_m, mem_write_m  out 1 each   control bits
//  flags        out  4              NZCV register
// BEHAVIOUR
//  Reset: all registers and outputs 0; valid_m=0; ldu_stall=0.
//  ID/EX register: on each edge loads the D inputs.
//   - stall_e=1: contents held.
//   - flush_e=1: bubble (valid=0, all write enables 0). Flush wins over stall.
//  EX/MEM register loads the E results every cycle.
//   - When stall_e=1 it receives a bubble instead.
//   - Latency D->M is 2 edges.
//  Forwarding of each source, priority M > W > register file:
//   - Matches only if the producer is valid (M stage) and its reg_write is set.
//   - M source is alu_result_m and is never taken while mem_to_reg_m=1.
//  ALU ops (per lane, B = imm or forwarded rd2):
//   - ADD=0, SUB=1, AND=2, ORR=3, EOR=4, MOVB=5.
//   - LSL=6, LSR=7: shift by B[4:0]; amounts >= WIDTH give 0.
//   - CMP=8: SUB, reg_write forced to 0.
//   - Unlisted opcodes: result 0.
//  SAT_EN=1: ADD/SUB clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//  Flags: NZCV from lane 0, computed on the unsaturated result. Updated only when valid_e & flag_write_e.
//  Addresses: addr_p = res0[ADDR_W-1:0] + STRIDE, addr_n = res0[ADDR_W-1:0] - STRIDE, both modulo 2^ADDR_W.
//  ldu_stall is combinational; it is 1 when all of these hold:
//   - valid_e & mem_to_reg_e
//   - wa3_e == ra1_d or ra2_d
//   - valid_d
//  ldu_stall is not gated by stall_e.
//  Reset mid-operation: all in-flight instructions are discarded; no partial M writes.
// STRUCTURE
//  gpu_pkg: alu_op_t enum, flags_t struct {n,z,c,v}, and the LANES/WIDTH defaults.
//  Sub-module vec_alu_lane (combinational WIDTH-bit ALU + carry/overflow) instantiated LANES times via generate.
//  Pipeline registers, forwarding and hazard logic live in this module.
// TESTING
//  1. Reset mid-stream: RST during a valid ADD -> all outputs 0 asynchronously; valid_m=0 one edge after release.
//  2. ADD back-to-back, r1 <- r2+r3 then r4 <- r1+r1, LANES=3, r2=5, r3=7 -> second alu_result_m={24,24,24} via M forward.
//  3. W vs M priority: r1 pending in both W (value 3) and M (value 9) -> operand uses 9.
//  4. Load-use: mem_to_reg_e=1, wa3_e=2, ra1_d=2 -> ldu_stall=1. With stall_e=1 next edge: bubble in M, E held.
//  5. Saturation: SAT_EN=1, WIDTH=18, 131071+1 -> 131071 and flags V=1. SAT_EN=0 -> -131072.
//  6. Addresses: lane0 result 0, STRIDE=1 -> addr_n_m=1023, addr_p_m=1. Simultaneous stall_e+flush_e -> bubble.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types for the filter GPU execute path: ALU opcodes, NZCV flag layout
// and the default vector geometry.
package gpu_pkg;

  localparam int LANES_DEF = 3;
  localparam int WIDTH_DEF = 18;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_ORR  = 4'd3,
    ALU_EOR  = 4'd4,
    ALU_MOVB = 4'd5,
    ALU_LSL  = 4'd6,
    ALU_LSR  = 4'd7,
    ALU_CMP  = 4'd8
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/vec_alu_lane.sv
// One lane of the SIMD ALU: combinational WIDTH-bit operation with NZCV taken
// from the unsaturated result, optional signed saturation on ADD/SUB/CMP.
module vec_alu_lane
  import gpu_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SAT_EN = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output flags_t           nzcv
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // On signed overflow the true result lies beyond the range on the side of a's sign.
  function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] raw,
                                                 input logic ovf, input logic a_neg);
    if (SAT_EN != 0 && ovf) return a_neg ? MIN_NEG : MAX_POS;
    return raw;
  endfunction

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] raw;
  logic             c;
  logic             v;
  logic             arith;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    raw   = '0;
    c     = 1'b0;
    v     = 1'b0;
    arith = 1'b0;
    case (alu_op_t'(op))
      ALU_ADD: begin
        raw   = sum[WIDTH-1:0];
        c     = sum[WIDTH];
        v     = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        arith = 1'b1;
      end
      ALU_SUB, ALU_CMP: begin
        raw   = diff[WIDTH-1:0];
        c     = diff[WIDTH];
        v     = (a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        arith = 1'b1;
      end
      ALU_AND:  raw = a & b;
      ALU_ORR:  raw = a | b;
      ALU_EOR:  raw = a ^ b;
      ALU_MOVB: raw = b;
      ALU_LSL:  raw = (int'(b[4:0]) >= WIDTH) ? '0 : (a << b[4:0]);
      ALU_LSR:  raw = (int'(b[4:0]) >= WIDTH) ? '0 : (a >> b[4:0]);
      default:  raw = '0;
    endcase
    result = arith ? sat_clamp(raw, v, a[WIDTH-1]) : raw;
    nzcv   = '{n: raw[WIDTH-1], z: (raw == '0), c: c, v: v};
  end

endmodule

// File: rtl/vec_exec_stage.sv
// SIMD execute stage: ID/EX register, M/W operand forwarding, per-lane ALU,
// neighbour address generation, NZCV storage, load-use detection, EX/MEM register.
module vec_exec_stage
  import gpu_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = 10,
  parameter int STRIDE = 1,
  parameter int SAT_EN = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   valid_d,
  input  logic [LANES*WIDTH-1:0] rd1_d,
  input  logic [LANES*WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0]       imm_d,
  input  logic [3:0]             ra1_d,
  input  logic [3:0]             ra2_d,
  input  logic [3:0]             wa3_d,
  input  logic [3:0]             alu_ctrl_d,
  input  logic                   alu_src_d,
  input  logic                   reg_write_d,
  input  logic                   mem_to_reg_d,
  input  logic                   mem_write_d,
  input  logic                   flag_write_d,
  input  logic                   stall_e,
  input  logic                   flush_e,
  input  logic [3:0]             wa3_w,
  input  logic                   reg_write_w,
  input  logic [LANES*WIDTH-1:0] result_w,
  output logic                   ldu_stall,
  output logic                   valid_m,
  output logic [LANES*WIDTH-1:0] alu_result_m,
  output logic [LANES*WIDTH-1:0] write_data_m,
  output logic [ADDR_W-1:0]      addr_p_m,
  output logic [ADDR_W-1:0]      addr_n_m,
  output logic [3:0]             wa3_m,
  output logic                   reg_write_m,
  output logic                   mem_to_reg_m,
  output logic                   mem_write_m,
  output logic [3:0]             flags
);

  localparam int VW = LANES * WIDTH;

  typedef struct packed {
    logic          valid;
    logic [VW-1:0] rd1;
    logic [VW-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [3:0]    ra1;
    logic [3:0]    ra2;
    logic [3:0]    wa3;
    logic [3:0]    alu_ctrl;
    logic          alu_src;
    logic          reg_write;
    logic          mem_to_reg;
    logic          mem_write;
    logic          flag_write;
  } idex_t;

  typedef struct packed {
    logic              valid;
    logic [VW-1:0]     alu_result;
    logic [VW-1:0]     write_data;
    logic [ADDR_W-1:0] addr_p;
    logic [ADDR_W-1:0] addr_n;
    logic [3:0]        wa3;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
  } exmem_t;

  idex_t   idex_q, idex_d;
  exmem_t  exmem_q, exmem_d;
  flags_t  flags_q, flags_d;

  logic          m_fwd_ok;
  logic [VW-1:0] fwd_a, fwd_b, op_b, alu_res_e;
  flags_t        lane_nzcv [LANES];

  // ---- D -> E boundary ----
  always_comb begin
    idex_d = idex_q;
    if (flush_e) begin
      idex_d = '0;
    end else if (!stall_e) begin
      idex_d = '{valid: valid_d, rd1: rd1_d, rd2: rd2_d, imm: imm_d,
                 ra1: ra1_d, ra2: ra2_d, wa3: wa3_d, alu_ctrl: alu_ctrl_d,
                 alu_src: alu_src_d, reg_write: reg_write_d,
                 mem_to_reg: mem_to_reg_d, mem_write: mem_write_d,
                 flag_write: flag_write_d};
    end
  end

  assign ldu_stall = idex_q.valid & idex_q.mem_to_reg & valid_d &
                     ((idex_q.wa3 == ra1_d) | (idex_q.wa3 == ra2_d));

  // A load in M has no data yet, so only ALU producers forward from M.
  always_comb begin
    m_fwd_ok = exmem_q.valid & exmem_q.reg_write & ~exmem_q.mem_to_reg;
    fwd_a = (m_fwd_ok && exmem_q.wa3 == idex_q.ra1) ? exmem_q.alu_result :
            (reg_write_w && wa3_w == idex_q.ra1)    ? result_w : idex_q.rd1;
    fwd_b = (m_fwd_ok && exmem_q.wa3 == idex_q.ra2) ? exmem_q.alu_result :
            (reg_write_w && wa3_w == idex_q.ra2)    ? result_w : idex_q.rd2;
    op_b  = idex_q.alu_src ? {LANES{idex_q.imm}} : fwd_b;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vec_alu_lane #(.WIDTH(WIDTH), .SAT_EN(SAT_EN)) u_lane (
      .a      (fwd_a[g*WIDTH +: WIDTH]),
      .b      (op_b[g*WIDTH +: WIDTH]),
      .op     (idex_q.alu_ctrl),
      .result (alu_res_e[g*WIDTH +: WIDTH]),
      .nzcv   (lane_nzcv[g])
    );
  end

  always_comb begin
    flags_d = flags_q;
    if (idex_q.valid && idex_q.flag_write) flags_d = lane_nzcv[0];
  end

  // ---- E -> M boundary ----
  always_comb begin
    exmem_d = '0;
    if (!stall_e) begin
      exmem_d.valid      = idex_q.valid;
      exmem_d.alu_result = alu_res_e;
      exmem_d.write_data = fwd_b;
      exmem_d.addr_p     = alu_res_e[ADDR_W-1:0] + ADDR_W'(STRIDE);
      exmem_d.addr_n     = alu_res_e[ADDR_W-1:0] - ADDR_W'(STRIDE);
      exmem_d.wa3        = idex_q.wa3;
      exmem_d.reg_write  = idex_q.valid & idex_q.reg_write &
                           (idex_q.alu_ctrl != 4'(ALU_CMP));
      exmem_d.mem_to_reg = idex_q.valid & idex_q.mem_to_reg;
      exmem_d.mem_write  = idex_q.valid & idex_q.mem_write;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idex_q  <= '0;
      exmem_q <= '0;
      flags_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      flags_q <= flags_d;
    end
  end

  assign valid_m      = exmem_q.valid;
  assign alu_result_m = exmem_q.alu_result;
  assign write_data_m = exmem_q.write_data;
  assign addr_p_m     = exmem_q.addr_p;
  assign addr_n_m     = exmem_q.addr_n;
  assign wa3_m        = exmem_q.wa3;
  assign reg_write_m  = exmem_q.reg_write;
  assign mem_to_reg_m = exmem_q.mem_to_reg;
  assign mem_write_m  = exmem_q.mem_write;
  assign flags        = flags_q;

endmodule

// File: tb/tb_vec_exec_stage.sv
// Bench for vec_exec_stage: a wrapping and a saturating instance driven by the
// same stimulus, checked each cycle against an arithmetic pipeline model.
module tb_vec_exec_stage;
  localparam int L = 3, W = 18, AW = 10, VW = L * W;
  localparam longint TWO_W = longint'(1) << W;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  logic CLK = 1'b0, RST;
  logic valid_d, alu_src_d, reg_write_d, mem_to_reg_d, mem_write_d, flag_write_d;
  logic stall_e, flush_e, reg_write_w;
  logic [VW-1:0] rd1_d, rd2_d, result_w;
  logic [W-1:0]  imm_d;
  logic [3:0]    ra1_d, ra2_d, wa3_d, alu_ctrl_d, wa3_w;

  logic          ldu_o [2], vm_o [2], rw_o [2], m2r_o [2], mw_o [2];
  logic [VW-1:0] res_o [2], wd_o [2];
  logic [AW-1:0] ap_o [2], an_o [2];
  logic [3:0]    wa3_o [2], fl_o [2];

  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  for (genvar s = 0; s < 2; s++) begin : g_dut
    vec_exec_stage #(.LANES(L), .WIDTH(W), .ADDR_W(AW), .STRIDE(1), .SAT_EN(s)) dut (
      .CLK(CLK), .RST(RST), .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
      .imm_d(imm_d), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
      .alu_ctrl_d(alu_ctrl_d), .alu_src_d(alu_src_d), .reg_write_d(reg_write_d),
      .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
      .flag_write_d(flag_write_d), .stall_e(stall_e), .flush_e(flush_e),
      .wa3_w(wa3_w), .reg_write_w(reg_write_w), .result_w(result_w),
      .ldu_stall(ldu_o[s]), .valid_m(vm_o[s]), .alu_result_m(res_o[s]),
      .write_data_m(wd_o[s]), .addr_p_m(ap_o[s]), .addr_n_m(an_o[s]),
      .wa3_m(wa3_o[s]), .reg_write_m(rw_o[s]), .mem_to_reg_m(m2r_o[s]),
      .mem_write_m(mw_o[s]), .flags(fl_o[s]));
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic valid; logic [VW-1:0] rd1, rd2; logic [W-1:0] imm;
    logic [3:0] ra1, ra2, wa3, op; logic src, rw, m2r, mw, fw;
  } ex_t;
  typedef struct {
    logic valid; logic [VW-1:0] res, wd; logic [AW-1:0] ap, an;
    logic [3:0] wa3; logic rw, m2r, mw;
  } mem_t;

  ex_t        me;
  mem_t       mm [2];
  logic [3:0] mf [2];

  task automatic model_reset();
    me = '{default: '0};
    for (int s = 0; s < 2; s++) begin mm[s] = '{default: '0}; mf[s] = '0; end
  endtask

  function automatic void lane_op(input logic [3:0] op, input logic [W-1:0] a, b,
                                  input bit sat, output logic [W-1:0] r,
                                  output logic [3:0] nzcv);
    longint ua = longint'(a), ub = longint'(b);
    longint sa = a[W-1] ? ua - TWO_W : ua;
    longint sb = b[W-1] ? ub - TWO_W : ub;
    longint full = 0, raw = 0, sh = ub % 32;
    bit c = 0, v = 0, arith = 0;
    case (op)
      4'd0: begin full = sa + sb; c = (ua + ub) >= TWO_W; arith = 1; end
      4'd1, 4'd8: begin full = sa - sb; c = ua >= ub; arith = 1; end
      4'd2: raw = ua & ub;
      4'd3: raw = ua | ub;
      4'd4: raw = ua ^ ub;
      4'd5: raw = ub;
      4'd6: raw = (sh >= W) ? 0 : (ua << sh) % TWO_W;
      4'd7: raw = (sh >= W) ? 0 : (ua >> sh);
      default: raw = 0;
    endcase
    if (arith) begin
      raw = ((full % TWO_W) + TWO_W) % TWO_W;
      v = (full > SMAX) || (full < SMIN);
    end
    r = raw[W-1:0];
    if (arith && sat && v) r = (full > SMAX) ? W'(SMAX) : W'(SMIN);
    nzcv = {raw[W-1], raw == 0, c, v};
  endfunction

  function automatic logic [VW-1:0] fwd(int s, logic [3:0] r, logic [VW-1:0] rf);
    if (mm[s].valid && mm[s].rw && !mm[s].m2r && mm[s].wa3 == r) return mm[s].res;
    if (reg_write_w && wa3_w == r) return result_w;
    return rf;
  endfunction

  task automatic model_edge();
    mem_t nm [2];
    logic [VW-1:0] a, br, bb, res;
    logic [W-1:0] r;
    logic [3:0] nz, nz0;
    for (int s = 0; s < 2; s++) begin
      a  = fwd(s, me.ra1, me.rd1);
      br = fwd(s, me.ra2, me.rd2);
      bb = me.src ? {L{me.imm}} : br;
      nz0 = '0;
      for (int l = 0; l < L; l++) begin
        lane_op(me.op, a[l*W +: W], bb[l*W +: W], s == 1, r, nz);
        res[l*W +: W] = r;
        if (l == 0) nz0 = nz;
      end
      nm[s] = '{default: '0};
      if (!stall_e) begin
        nm[s].valid = me.valid; nm[s].res = res; nm[s].wd = br;
        nm[s].ap = res[AW-1:0] + AW'(1); nm[s].an = res[AW-1:0] - AW'(1);
        nm[s].wa3 = me.wa3; nm[s].rw = me.valid & me.rw & (me.op != 4'd8);
        nm[s].m2r = me.valid & me.m2r; nm[s].mw = me.valid & me.mw;
      end
      if (me.valid && me.fw) mf[s] = nz0;
    end
    mm = nm;
    if (flush_e) me = '{default: '0};
    else if (!stall_e)
      me = '{valid: valid_d, rd1: rd1_d, rd2: rd2_d, imm: imm_d, ra1: ra1_d,
             ra2: ra2_d, wa3: wa3_d, op: alu_ctrl_d, src: alu_src_d,
             rw: reg_write_d, m2r: mem_to_reg_d, mw: mem_write_d, fw: flag_write_d};
  endtask

  task automatic cmp_out();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("valid_m%0d", s), vm_o[s], mm[s].valid);
      chk($sformatf("alu_result_m%0d", s), res_o[s], mm[s].res);
      chk($sformatf("write_data_m%0d", s), wd_o[s], mm[s].wd);
      chk($sformatf("addr_p_m%0d", s), ap_o[s], mm[s].ap);
      chk($sformatf("addr_n_m%0d", s), an_o[s], mm[s].an);
      chk($sformatf("wa3_m%0d", s), wa3_o[s], mm[s].wa3);
      chk($sformatf("ctrl_m%0d", s), {rw_o[s], m2r_o[s], mw_o[s]},
          {mm[s].rw, mm[s].m2r, mm[s].mw});
      chk($sformatf("flags%0d", s), fl_o[s], mf[s]);
    end
  endtask

  // Inputs are applied at the falling edge; one call covers one rising edge.
  task automatic step();
    #1;
    for (int s = 0; s < 2; s++)
      chk($sformatf("ldu_stall%0d", s), ldu_o[s],
          me.valid & me.m2r & valid_d & ((me.wa3 == ra1_d) | (me.wa3 == ra2_d)));
    model_edge();
    @(posedge CLK);
    #1;
    cmp_out();
    @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  task automatic idle();
    valid_d = 0; rd1_d = '0; rd2_d = '0; imm_d = '0; ra1_d = 0; ra2_d = 0; wa3_d = 0;
    alu_ctrl_d = 0; alu_src_d = 0; reg_write_d = 0; mem_to_reg_d = 0; mem_write_d = 0;
    flag_write_d = 0; stall_e = 0; flush_e = 0; wa3_w = 0; reg_write_w = 0; result_w = '0;
  endtask

  task automatic issue(input logic [3:0] op, ra1, ra2, wa3, input logic [W-1:0] v1, v2, imm,
                       input logic src, rw, m2r, fw);
    idle();
    valid_d = 1; alu_ctrl_d = op; ra1_d = ra1; ra2_d = ra2; wa3_d = wa3;
    rd1_d = {L{v1}}; rd2_d = {L{v2}}; imm_d = imm;
    alu_src_d = src; reg_write_d = rw; mem_to_reg_d = m2r; flag_write_d = fw;
  endtask

  function automatic logic [W-1:0] rval();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return W'(1);
      2: return W'(SMAX);
      3: return W'(SMIN);
      4: return '1;
      5: return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    idle();
    RST = 1;
    model_reset();
    @(negedge CLK);
    chk("reset_valid_m", vm_o[0], 0);
    chk("reset_alu_result", res_o[0], 0);
    chk("reset_flags", fl_o[0], 0);
    chk("reset_ldu", ldu_o[0], 0);
    RST = 0;

    // Reset asserted while a valid ADD sits in M.
    issue(4'd0, 4'd9, 4'd9, 4'd1, 18'd4, 18'd6, '0, 0, 1, 0, 1);
    step();
    idle(); step();
    chk("pre_reset_valid_m", vm_o[0], 1);
    #1 RST = 1;
    #1;
    chk("async_valid_m", vm_o[0], 0);
    chk("async_alu_result", res_o[0], 0);
    chk("async_reg_write_m", rw_o[0], 0);
    chk("async_flags", fl_o[0], 0);
    #1 RST = 0;
    model_reset();
    issue(4'd0, 4'd9, 4'd9, 4'd1, 18'd4, 18'd6, '0, 0, 1, 0, 1);
    step();
    chk("post_release_valid_m", vm_o[0], 0);
    idle(); step(); step();

    // r1 <- r2 + r3, then r4 <- r1 + r1 through M forwarding.
    issue(4'd0, 4'd2, 4'd3, 4'd1, 18'd5, 18'd7, '0, 0, 1, 0, 0);
    step();
    issue(4'd0, 4'd1, 4'd1, 4'd4, '0, '0, '0, 0, 1, 0, 0);
    step();
    idle(); step();
    chk("fwd_add_result", res_o[0], {18'd24, 18'd24, 18'd24});

    // r1 pending in M (9) and W (3): M wins.
    issue(4'd5, 4'd0, 4'd0, 4'd1, '0, '0, 18'd9, 1, 1, 0, 0);
    step();
    issue(4'd0, 4'd1, 4'd6, 4'd5, 18'd100, '0, '0, 1, 1, 0, 0);
    step();
    idle(); wa3_w = 4'd1; reg_write_w = 1; result_w = {L{18'd3}};
    step();
    chk("fwd_m_over_w", res_o[0], {18'd9, 18'd9, 18'd9});
    idle(); step();

    // Load-use hazard with stall.
    issue(4'd0, 4'd7, 4'd7, 4'd2, '0, '0, 18'd64, 1, 1, 1, 0);
    step();
    issue(4'd0, 4'd2, 4'd7, 4'd3, '0, '0, '0, 0, 1, 0, 0);
    stall_e = 1;
    #1 chk("ldu_hit", ldu_o[0], 1);
    step();
    chk("ldu_bubble_m", vm_o[0], 0);
    chk("ldu_e_held", ldu_o[0], 1);
    stall_e = 0;
    step();
    idle(); step(); step();

    // Saturation: 131071 + 1.
    issue(4'd0, 4'd7, 4'd7, 4'd8, 18'h1FFFF, '0, 18'd1, 1, 1, 0, 1);
    step();
    idle(); step();
    chk("wrap_result", res_o[0], {3{18'h20000}});
    chk("sat_result", res_o[1], {3{18'h1FFFF}});
    chk("wrap_flags", fl_o[0], 4'b1001);
    chk("sat_flags", fl_o[1], 4'b1001);

    // Neighbour addresses around zero, then stall+flush together.
    issue(4'd0, 4'd7, 4'd7, 4'd8, '0, '0, '0, 1, 1, 0, 0);
    step();
    idle(); step();
    chk("addr_n_wrap", an_o[0], 10'd1023);
    chk("addr_p", ap_o[0], 10'd1);
    issue(4'd0, 4'd7, 4'd7, 4'd8, 18'd1, '0, 18'd1, 1, 1, 0, 0);
    step();
    issue(4'd0, 4'd7, 4'd7, 4'd9, 18'd2, '0, 18'd1, 1, 1, 0, 0);
    stall_e = 1; flush_e = 1;
    step();
    chk("stall_flush_m", vm_o[0], 0);
    idle(); step();
    chk("stall_flush_e", vm_o[0], 0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      idle();
      for (int l = 0; l < L; l++) begin
        rd1_d[l*W +: W] = rval(); rd2_d[l*W +: W] = rval(); result_w[l*W +: W] = rval();
      end
      imm_d = rval();
      ra1_d = 4'($urandom_range(0, 3)); ra2_d = 4'($urandom_range(0, 3));
      wa3_d = 4'($urandom_range(0, 3)); wa3_w = 4'($urandom_range(0, 3));
      reg_write_w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        valid_d = 1; alu_ctrl_d = 4'($urandom_range(0, 10));
        alu_src_d = 1'($urandom_range(0, 1)); reg_write_d = 1'($urandom_range(0, 1));
        mem_to_reg_d = ($urandom_range(0, 3) == 0); mem_write_d = ($urandom_range(0, 3) == 0);
        flag_write_d = 1'($urandom_range(0, 1));
      end
      stall_e = ($urandom_range(0, 5) == 0);
      flush_e = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
